dpi_issue_queue: RTL and testbench

- Reservation station and issue queue that drives the fu_if input side of the data-processing-immediate functional unit: inst_valid, inst, pc, op[0], out_prn and inst_id.
- Accepts renamed instructions from dispatch and holds them until their single source operand is available.
- Captures the operand value from the writeback broadcast bus.
- Issues the oldest ready entry to the FU, at most one per cycle, only while the FU reports fu_ready.

---
 rtl/foxtrot_pkg.sv | 34 +++
 rtl/dpi_issue_queue_rs_oldest_select.sv | 30 +++
 rtl/dpi_issue_queue.sv | 184 ++++++++++++++++++
 tb/tb_dpi_issue_queue.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/foxtrot_pkg.sv
// Shared types and helpers for the data-processing-immediate issue queue.
//
// Contents:
//   PRN_W_DEF / ID_W_DEF : default physical-register-number and instruction-id widths
//   rs_entry_t           : one reservation-station slot
//   rs_wake              : returns an entry marked ready with a captured operand value
//
// The entry fields are sized by PRN_W_DEF / ID_W_DEF, so a queue instance must
// use these same widths for its PRN_W / ID_W parameters.
package foxtrot_pkg;

    localparam int PRN_W_DEF = 7;
    localparam int ID_W_DEF  = 6;

    typedef struct packed {
        logic                 valid;
        logic                 rdy;
        logic [31:0]          inst;
        logic [63:0]          pc;
        logic [PRN_W_DEF-1:0] src_prn;
        logic [63:0]          val;
        logic [PRN_W_DEF-1:0] out_prn;
        logic [ID_W_DEF-1:0]  inst_id;
    } rs_entry_t;

    function automatic rs_entry_t rs_wake(input rs_entry_t e, input logic [63:0] data);
        rs_entry_t r;
        r     = e;
        r.rdy = 1'b1;
        r.val = data;
        return r;
    endfunction

endpackage

// File: rtl/dpi_issue_queue_rs_oldest_select.sv
// rs_oldest_select: priority encoder that finds the lowest-index asserted
// request. Index 0 is the oldest queue slot, so this picks the oldest ready entry.
//
// Ports:
//   req_i   [DEPTH]         per-slot "ready to issue" flags
//   idx_o   [clog2(DEPTH)]  lowest asserted index (0 when none)
//   found_o                 at least one request asserted
module rs_oldest_select #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]         req_i,
    output logic [$clog2(DEPTH)-1:0] idx_o,
    output logic                     found_o
);

    localparam int IDX_W = $clog2(DEPTH);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dpi_issue_queue.sv
// dpi_issue_queue: reservation station / issue queue feeding the
// data-processing-immediate functional unit.
//
// Holds renamed instructions until their single source operand is available
// (either at dispatch, via same-cycle broadcast bypass, or via a later
// writeback broadcast), then issues the oldest ready entry while the FU is ready.
// Storage is a compacting queue: slot 0 is always the oldest entry.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   flush                            discard all entries (below rst, above all else)
//   disp_valid / disp_ready          dispatch handshake; disp_ready = count < DEPTH
//   disp_inst, disp_pc               instruction word and PC
//   disp_src_prn/_rdy/_val           source operand tag, ready flag and value
//   disp_out_prn, disp_inst_id       destination PRN and instruction id
//   cdb_valid, cdb_prn, cdb_data     writeback broadcast
//   fu_ready                         FU can accept an instruction this cycle
//   iss_*                            registered issue outputs; iss_inst_valid is a
//                                    one-cycle strobe, data holds between issues
module dpi_issue_queue
    import foxtrot_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PRN_W = PRN_W_DEF,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [31:0]      disp_inst,
    input  logic [63:0]      disp_pc,
    input  logic [PRN_W-1:0] disp_src_prn,
    input  logic             disp_src_rdy,
    input  logic [63:0]      disp_src_val,
    input  logic [PRN_W-1:0] disp_out_prn,
    input  logic [ID_W-1:0]  disp_inst_id,
    input  logic             cdb_valid,
    input  logic [PRN_W-1:0] cdb_prn,
    input  logic [63:0]      cdb_data,
    input  logic             fu_ready,
    output logic             iss_inst_valid,
    output logic [31:0]      iss_inst,
    output logic [63:0]      iss_pc,
    output logic [63:0]      iss_op0,
    output logic [PRN_W-1:0] iss_out_prn,
    output logic [ID_W-1:0]  iss_inst_id
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    rs_entry_t        entries_q [DEPTH];
    rs_entry_t        entries_d [DEPTH];
    rs_entry_t        woken     [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;

    logic             iss_valid_q;
    logic [31:0]      iss_inst_q;
    logic [63:0]      iss_pc_q;
    logic [63:0]      iss_op0_q;
    logic [PRN_W-1:0] iss_out_prn_q;
    logic [ID_W-1:0]  iss_inst_id_q;

    logic [DEPTH-1:0] cand;
    logic [DEPTH-1:0] wake_hit;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             issue_fire;
    logic             enq_fire;
    rs_entry_t        sel_entry;
    rs_entry_t        enq_entry;

    // Candidates use the registered rdy bit only, so an entry woken on an edge
    // can issue no earlier than the following edge.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign cand[gi]     = entries_q[gi].valid && entries_q[gi].rdy;
            assign wake_hit[gi] = cdb_valid && entries_q[gi].valid && !entries_q[gi].rdy
                                  && (entries_q[gi].src_prn == cdb_prn);
            assign woken[gi]    = wake_hit[gi] ? rs_wake(entries_q[gi], cdb_data)
                                               : entries_q[gi];
        end
    endgenerate

    rs_oldest_select #(
        .DEPTH (DEPTH)
    ) u_select (
        .req_i   (cand),
        .idx_o   (sel_idx),
        .found_o (sel_found)
    );

    assign disp_ready = (count_q < CNT_W'(DEPTH));
    assign issue_fire = sel_found && fu_ready && !flush;
    assign enq_fire   = disp_valid && disp_ready && !flush;
    assign sel_entry  = entries_q[sel_idx];

    // New entry: a broadcast matching the source tag in the dispatch cycle is
    // bypassed straight into the slot so the entry is born ready.
    always_comb begin
        enq_entry         = '0;
        enq_entry.valid   = 1'b1;
        enq_entry.rdy     = disp_src_rdy || (cdb_valid && (cdb_prn == disp_src_prn));
        enq_entry.inst    = disp_inst;
        enq_entry.pc      = disp_pc;
        enq_entry.src_prn = disp_src_prn;
        enq_entry.val     = disp_src_rdy ? disp_src_val : cdb_data;
        enq_entry.out_prn = disp_out_prn;
        enq_entry.inst_id = disp_inst_id;
    end

    // Next state: wakeup, then compaction of the issued slot, then enqueue at
    // the post-compaction tail, with flush overriding everything.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = woken[i];
        end
        count_d = count_q;

        if (issue_fire) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IDX_W'(i) >= sel_idx) begin
                    entries_d[i] = woken[i + 1];
                end
            end
            entries_d[DEPTH - 1] = '0;
            count_d = count_q - 1'b1;
        end

        if (enq_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == count_d) begin
                    entries_d[i] = enq_entry;
                end
            end
            count_d = count_d + 1'b1;
        end

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i] = '0;
            end
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q       <= '0;
            iss_valid_q   <= 1'b0;
            iss_inst_q    <= '0;
            iss_pc_q      <= '0;
            iss_op0_q     <= '0;
            iss_out_prn_q <= '0;
            iss_inst_id_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            count_q     <= count_d;
            iss_valid_q <= issue_fire;
            if (issue_fire) begin
                iss_inst_q    <= sel_entry.inst;
                iss_pc_q      <= sel_entry.pc;
                iss_op0_q     <= sel_entry.val;
                iss_out_prn_q <= sel_entry.out_prn;
                iss_inst_id_q <= sel_entry.inst_id;
            end
        end
    end

    assign iss_inst_valid = iss_valid_q;
    assign iss_inst       = iss_inst_q;
    assign iss_pc         = iss_pc_q;
    assign iss_op0        = iss_op0_q;
    assign iss_out_prn    = iss_out_prn_q;
    assign iss_inst_id    = iss_inst_id_q;

endmodule

// File: tb/tb_dpi_issue_queue.sv
module tb_dpi_issue_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    logic [31:0] disp_inst;
    logic [63:0] disp_pc;
    logic [6:0]  disp_src_prn;
    logic        disp_src_rdy;
    logic [63:0] disp_src_val;
    logic [6:0]  disp_out_prn;
    logic [5:0]  disp_inst_id;
    logic        cdb_valid;
    logic [6:0]  cdb_prn;
    logic [63:0] cdb_data;
    logic        fu_ready;
    logic        iss_inst_valid;
    logic [31:0] iss_inst;
    logic [63:0] iss_pc;
    logic [63:0] iss_op0;
    logic [6:0]  iss_out_prn;
    logic [5:0]  iss_inst_id;

    int n_checks = 0;
    int n_fail   = 0;

    dpi_issue_queue #(
        .DEPTH (4),
        .PRN_W (7),
        .ID_W  (6)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .disp_valid     (disp_valid),
        .disp_ready     (disp_ready),
        .disp_inst      (disp_inst),
        .disp_pc        (disp_pc),
        .disp_src_prn   (disp_src_prn),
        .disp_src_rdy   (disp_src_rdy),
        .disp_src_val   (disp_src_val),
        .disp_out_prn   (disp_out_prn),
        .disp_inst_id   (disp_inst_id),
        .cdb_valid      (cdb_valid),
        .cdb_prn        (cdb_prn),
        .cdb_data       (cdb_data),
        .fu_ready       (fu_ready),
        .iss_inst_valid (iss_inst_valid),
        .iss_inst       (iss_inst),
        .iss_pc         (iss_pc),
        .iss_op0        (iss_op0),
        .iss_out_prn    (iss_out_prn),
        .iss_inst_id    (iss_inst_id)
    );

    always #5 clk = ~clk;

    // One line per issued instruction.
    always @(negedge clk) begin
        if (!rst && iss_inst_valid === 1'b1)
            $display("issue: id=%0d inst=%08h pc=%0h op0=%016h out_prn=%0d",
                     iss_inst_id, iss_inst, iss_pc, iss_op0, iss_out_prn);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic disp(input logic [31:0] inst, input logic [63:0] pc, input logic [6:0] src,
                        input logic src_rdy, input logic [63:0] val, input logic [6:0] outp,
                        input logic [5:0] id);
        disp_valid   = 1'b1;
        disp_inst    = inst;
        disp_pc      = pc;
        disp_src_prn = src;
        disp_src_rdy = src_rdy;
        disp_src_val = val;
        disp_out_prn = outp;
        disp_inst_id = id;
    endtask

    task automatic bcast(input logic [6:0] prn, input logic [63:0] data);
        cdb_valid = 1'b1;
        cdb_prn   = prn;
        cdb_data  = data;
    endtask

    task automatic expect_issue(input string tag, input logic [5:0] id, input logic [63:0] op0);
        check({tag, "_valid"}, 64'(iss_inst_valid), 64'd1);
        check({tag, "_id"},    64'(iss_inst_id),    64'(id));
        check({tag, "_op0"},   iss_op0,             op0);
    endtask

    task automatic expect_none(input string tag);
        check(tag, 64'(iss_inst_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; cdb_valid = 1'b0; fu_ready = 1'b1;
        disp_inst = '0; disp_pc = '0; disp_src_prn = '0; disp_src_rdy = 1'b0;
        disp_src_val = '0; disp_out_prn = '0; disp_inst_id = '0; cdb_prn = '0; cdb_data = '0;
        tick(); tick();

        // Reset state
        check("rst_valid", 64'(iss_inst_valid), 64'd0);
        check("rst_inst",  64'(iss_inst),       64'd0);
        check("rst_op0",   iss_op0,             64'd0);
        check("rst_ready", 64'(disp_ready),     64'd1);
        rst = 1'b0;
        tick();

        // 1: ready MOVZ issues two edges after dispatch
        disp(32'hD2824680, 64'h1000, 7'd0, 1'b1, 64'd0, 7'd5, 6'd3);
        tick(); idle();
        expect_none("t1_e0");
        tick();
        check("t1_valid", 64'(iss_inst_valid), 64'd1);
        check("t1_inst",  64'(iss_inst),       64'hD2824680);
        check("t1_pc",    iss_pc,              64'h1000);
        check("t1_prn",   64'(iss_out_prn),    64'd5);
        check("t1_id",    64'(iss_inst_id),    64'd3);
        tick();
        expect_none("t1_strobe");
        check("t1_hold",  64'(iss_inst),       64'hD2824680);

        // 2: MOVK waits for prn 9
        disp(32'hF2A00000, 64'h1004, 7'd9, 1'b0, 64'd0, 7'd6, 6'd4);
        tick(); idle();
        expect_none("t2_e0");
        tick(); expect_none("t2_e1");
        tick(); expect_none("t2_e2");
        bcast(7'd9, 64'hDEAD_BEEF_0000_0000);
        tick(); idle();
        expect_none("t2_wake_edge");
        tick();
        expect_issue("t2", 6'd4, 64'hDEAD_BEEF_0000_0000);
        tick();

        // 3: fill with FU stalled, overflow dispatch ignored, then drain in order
        fu_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            disp(32'hD2800000 + 32'(i), 64'h2000 + 64'(4 * i), 7'd0, 1'b1, 64'h100 + 64'(i), 7'(10 + i), 6'(i));
            tick();
        end
        idle();
        check("t3_full_ready", 64'(disp_ready), 64'd0);
        expect_none("t3_stalled");
        disp(32'hD2800009, 64'h2100, 7'd0, 1'b1, 64'h999, 7'd20, 6'd9);
        tick(); idle();
        check("t3_still_full", 64'(disp_ready), 64'd0);
        fu_ready = 1'b1;
        tick();
        expect_issue("t3_i1", 6'd1, 64'h101);
        check("t3_ready_back", 64'(disp_ready), 64'd1);
        tick(); expect_issue("t3_i2", 6'd2, 64'h102);
        tick(); expect_issue("t3_i3", 6'd3, 64'h103);
        tick(); expect_issue("t3_i4", 6'd4, 64'h104);
        check("t3_pc4", iss_pc, 64'h2010);
        tick(); expect_none("t3_empty");

        // 4: same-cycle broadcast bypass at dispatch
        disp(32'hF2800000, 64'h3000, 7'd12, 1'b0, 64'd0, 7'd30, 6'd7);
        bcast(7'd12, 64'h77);
        tick(); idle();
        expect_none("t4_e0");
        tick();
        expect_issue("t4", 6'd7, 64'h77);
        tick();

        // 5: ready entry overtakes a waiting one; issue + enqueue compaction
        disp(32'hF2800001, 64'h4000, 7'd4, 1'b0, 64'd0, 7'd40, 6'd1);
        tick();
        disp(32'hD2800002, 64'h4004, 7'd0, 1'b1, 64'h22, 7'd41, 6'd2);
        tick();
        disp(32'hF2800003, 64'h4008, 7'd4, 1'b0, 64'd0, 7'd42, 6'd3);
        tick(); idle();
        expect_issue("t5_i2", 6'd2, 64'h22);
        bcast(7'd4, 64'h44);
        tick(); idle();
        expect_none("t5_wake_edge");
        tick(); expect_issue("t5_i1", 6'd1, 64'h44);
        check("t5_pc1", iss_pc, 64'h4000);
        tick(); expect_issue("t5_i3", 6'd3, 64'h44);
        check("t5_pc3", iss_pc, 64'h4008);
        tick(); expect_none("t5_empty");

        // 6: flush with three entries and a dispatch pending
        fu_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            disp(32'hD2800010, 64'h5000 + 64'(4 * i), 7'd0, 1'b1, 64'h500 + 64'(i), 7'd50, 6'(10 + i));
            tick();
        end
        disp(32'hD2800013, 64'h500C, 7'd0, 1'b1, 64'h503, 7'd50, 6'd13);
        flush = 1'b1;
        tick(); idle();
        check("t6_ready", 64'(disp_ready), 64'd1);
        expect_none("t6_valid");
        // Three fresh entries fit only if count was cleared
        for (int i = 0; i < 3; i++) begin
            disp(32'hD2800020, 64'h6000 + 64'(4 * i), 7'd0, 1'b1, 64'h600 + 64'(i), 7'd60, 6'(20 + i));
            tick();
        end
        idle();
        check("t6_count3", 64'(disp_ready), 64'd1);
        fu_ready = 1'b1;
        tick(); expect_issue("t6_i20", 6'd20, 64'h600);
        tick(); expect_issue("t6_i21", 6'd21, 64'h601);
        tick(); expect_issue("t6_i22", 6'd22, 64'h602);
        tick(); expect_none("t6_no_stale");
        tick(); expect_none("t6_no_stale2");

        // Reset mid-operation zeroes issue data
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_inst", 64'(iss_inst), 64'd0);
        check("rst2_op0",  iss_op0,       64'd0);
        check("rst2_id",   64'(iss_inst_id), 64'd0);
        check("rst2_ready", 64'(disp_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
